// File: rtl/pipe_ctrl_gen.sv
// Pipelined MIPS control unit: decode in D, bundle carried through E, M1..Mn and W.
// Defining CTRL_PERF_EN adds the retired/flushed event counters and their ports.
module pipe_ctrl_gen #(
   parameter int MEM_LAT = 1,
   parameter int ALUC_W  = 3,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [5:0]        op,
   input  logic [5:0]        funct,
   input  logic              validD,
   input  logic              stallE,
   input  logic              flushE,
   input  logic              zeroE,
   output logic              jumpD,
   output logic              illegalD,
   output logic              validE,
   output logic              regwriteE,
   output logic              memtoregE,
   output logic              alusrcE,
   output logic              regdstE,
   output logic [ALUC_W-1:0] alucontrolE,
   output logic              pcsrcE,
   output logic              memwriteM,
   output logic              regwriteM,
   output logic              memtoregM,
   output logic              regwriteW,
   output logic              memtoregW
`ifdef CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0]  retired,
   output logic [CNT_W-1:0]  flushed
`endif
);

   typedef struct packed {
      logic       rw;
      logic       rd;
      logic       asrc;
      logic       mw;
      logic       mr;
      logic       beq;
      logic       bne;
      logic [2:0] alu;
   } ctrl_t;

   typedef struct packed {
      logic valid;
      logic rw;
      logic mr;
      logic mw;
   } mstage_t;

   ctrl_t   dec_next;
   logic    known;
   ctrl_t   e_reg;
   logic    e_valid_reg;
   mstage_t m_chain [MEM_LAT+1];
   logic    w_valid_reg;
   logic    w_rw_reg;
   logic    w_mr_reg;

   // Decode; unknown encodings and empty slots collapse to an all-zero bundle.
   always_comb begin
      dec_next = '0;
      known    = 1'b1;
      case (op)
         6'b000000: begin
            dec_next.rw = 1'b1;
            dec_next.rd = 1'b1;
            case (funct)
               6'b100000: dec_next.alu = 3'b010;
               6'b100010: dec_next.alu = 3'b110;
               6'b100100: dec_next.alu = 3'b000;
               6'b100101: dec_next.alu = 3'b001;
               6'b101010: dec_next.alu = 3'b111;
               default:   known = 1'b0;
            endcase
         end
         6'b100011: begin
            dec_next.rw   = 1'b1;
            dec_next.asrc = 1'b1;
            dec_next.mr   = 1'b1;
            dec_next.alu  = 3'b010;
         end
         6'b101011: begin
            dec_next.mw   = 1'b1;
            dec_next.asrc = 1'b1;
            dec_next.alu  = 3'b010;
         end
         6'b000100: begin
            dec_next.beq = 1'b1;
            dec_next.alu = 3'b110;
         end
         6'b000101: begin
            dec_next.bne = 1'b1;
            dec_next.alu = 3'b110;
         end
         6'b001000: begin
            dec_next.rw   = 1'b1;
            dec_next.asrc = 1'b1;
            dec_next.alu  = 3'b010;
         end
         6'b000010: ;
         default:   known = 1'b0;
      endcase
      if (!known || !validD) begin
         dec_next = '0;
      end
   end

   assign illegalD = validD & ~known;
   assign jumpD    = validD & (op == 6'b000010);

   always_ff @(posedge clk) begin
      if (reset || flushE) begin
         e_valid_reg <= 1'b0;
         e_reg       <= '0;
      end else if (!stallE) begin
         e_valid_reg <= validD;
         e_reg       <= dec_next;
      end
   end

   assign validE      = e_valid_reg;
   assign regwriteE   = e_reg.rw;
   assign memtoregE   = e_reg.mr;
   assign alusrcE     = e_reg.asrc;
   assign regdstE     = e_reg.rd;
   assign alucontrolE = ALUC_W'(e_reg.alu);
   assign pcsrcE      = e_valid_reg & ((e_reg.beq & zeroE) | (e_reg.bne & ~zeroE));

   // A stalled or flushed E never hands its contents on; M1 sees a bubble instead.
   assign m_chain[0] = (stallE || flushE || !e_valid_reg) ? '0
                     : '{valid: 1'b1, rw: e_reg.rw, mr: e_reg.mr, mw: e_reg.mw};

   for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_mstage
      mstage_t stage_reg;
      always_ff @(posedge clk) begin
         if (reset) begin
            stage_reg <= '0;
         end else begin
            stage_reg <= m_chain[gi];
         end
      end
      assign m_chain[gi+1] = stage_reg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_valid_reg <= 1'b0;
         w_rw_reg    <= 1'b0;
         w_mr_reg    <= 1'b0;
      end else begin
         w_valid_reg <= m_chain[MEM_LAT].valid;
         w_rw_reg    <= m_chain[MEM_LAT].rw;
         w_mr_reg    <= m_chain[MEM_LAT].mr;
      end
   end

   assign memwriteM = m_chain[1].valid & m_chain[1].mw;
   assign regwriteM = m_chain[MEM_LAT].valid & m_chain[MEM_LAT].rw;
   assign memtoregM = m_chain[MEM_LAT].valid & m_chain[MEM_LAT].mr;
   assign regwriteW = w_valid_reg & w_rw_reg;
   assign memtoregW = w_valid_reg & w_mr_reg;

`ifdef CTRL_PERF_EN
   logic [CNT_W-1:0] retired_reg;
   logic [CNT_W-1:0] flushed_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         retired_reg <= '0;
         flushed_reg <= '0;
      end else begin
         if (w_valid_reg) begin
            retired_reg <= retired_reg + CNT_W'(1);
         end
         if (flushE && e_valid_reg) begin
            flushed_reg <= flushed_reg + CNT_W'(1);
         end
      end
   end

   assign retired = retired_reg;
   assign flushed = flushed_reg;
`endif

endmodule

// File: doc/pipe_ctrl_gen.md
Name: pipe_ctrl_gen

Overview:
Parametrised pipelined control unit for the 5+ stage MIPS core.
- Decodes op/funct in D and carries the control bundle through E, a configurable number of memory stages (M1..Mn) and W.
- Supports stall and flush, per-stage valid bits, BEQ and BNE resolution in E, and illegal-opcode detection.
- Sits beside the datapath; the hazard unit drives stallE/flushE.

Parameters:
MEM_LAT, 1, number of memory stages M1..Mn (legal 1..4); the W stage follows Mn.
ALUC_W, 3, alucontrol width (>=3); bits above [2:0] are driven 0.
CNT_W, 32, counter width; used only with CTRL_PERF_EN.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
op  in  6  instruction opcode, D stage
funct  in  6  instruction funct, D stage
validD  in  1  D slot holds a real instruction
stallE  in  1  hold E register; insert bubble into M1
flushE  in  1  replace E contents with bubble
zeroE  in  1  ALU zero flag from E datapath
jumpD  out  1  validD & op==000010 (combinational)
illegalD  out  1  validD & unrecognised op/funct (combinational)
validE  out  1  E slot valid
regwriteE  out  1
memtoregE  out  1
alusrcE  out  1
regdstE  out  1
alucontrolE  out  ALUC_W
pcsrcE  out  1  validE & ((beqE & zeroE) | (bneE & ~zeroE))
memwriteM  out  1  M1-stage memory write enable
regwriteM  out  1  Mn-stage regwrite (forwarding)
memtoregM  out  1  Mn-stage memtoreg
regwriteW  out  1
memtoregW  out  1
retired  out  CNT_W  only with CTRL_PERF_EN
flushed  out  CNT_W  only with CTRL_PERF_EN

Behaviour:
- One clock domain. Every register has a synchronous active-high reset on clk/reset. All registered outputs and valid bits reset to 0.
- Decode table (fields: rw/rd/as/mw/mr/beq/bne, alucontrol):
  - op 000000 (R-type): rw=1, rd=1. funct selects alucontrol:
    - 100000 → 010
    - 100010 → 110
    - 100100 → 000
    - 100101 → 001
    - 101010 → 111
  - op 100011 (lw): rw=1, as=1, mr=1, alucontrol 010.
  - op 101011 (sw): mw=1, as=1, alucontrol 010.
  - op 000100 (beq): beq=1, alucontrol 110.
  - op 000101 (bne): bne=1, alucontrol 110.
  - op 001000 (addi): rw=1, as=1, alucontrol 010.
  - op 000010 (j): jumpD only; all bundle bits 0.
- Any other op, or R-type with another funct: illegalD=1, whole bundle forced to 0. The instruction still advances as a valid no-op.
- validD=0: bundle is 0 and the stage valid bit is 0.
- Pipeline register E, priority reset > flushE > stallE > load:
  - flushE: validE and all E bits ← 0.
  - stallE (no flush): E holds; M1 receives a bubble (valid=0, all bits 0).
  - otherwise: E ← D bundle.
  - flushE and stallE together: flush wins; M1 still gets a bubble.
- M1..Mn and W always advance; they are never stalled.
- Memory-stage side effects are gated by stage valid: memwriteM = valid M1 & mw, so a bubble never writes.
- Latency, unstalled: an instruction decoded in cycle t is in E at t+1, M1 at t+2, Mn at t+1+MEM_LAT, W at t+2+MEM_LAT.
- pcsrcE is combinational in E. Because it is gated by validE, a flushed branch never redirects.
- Reset asserted mid-stream clears every stage on the next edge. Instructions already in flight are discarded.

Optional Feature:
- Macro CTRL_PERF_EN.
- When defined, two CNT_W counters are added; both reset to 0 and wrap modulo 2^CNT_W:
  - retired: increments each cycle the W stage is valid.
  - flushed: increments each cycle flushE=1 and validE=1 (a real instruction is destroyed).
- When undefined: the retired and flushed ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. MEM_LAT=1: lw (op 100011) with validD=1 at t0 → at t1 regwriteE=1, alusrcE=1, memtoregE=1, alucontrolE=010; at t2 memtoregM=1, regwriteM=1; at t3 regwriteW=1, memtoregW=1.
2. MEM_LAT=3: sw at t0 → memwriteM=1 at t2 only; nothing written at W; regwriteW stays 0 throughout.
3. bne in E: zeroE=0 → pcsrcE=1; zeroE=1 → pcsrcE=0. beq in E with flushE at the same edge as load → validE=0 and pcsrcE=0 regardless of zeroE.
4. R-type funct 100010 in E with stallE=1 for 2 cycles:
   - E holds alucontrolE=110 for 3 cycles.
   - M1 gets 2 bubbles: memwriteM=0, valid 0.
   - The instruction reaches W exactly 2 cycles late.
5. op 111111 with validD=1 → illegalD=1 and zero bundle propagated. op 000010 → jumpD=1 in the same cycle, regwriteE=0 next cycle.
6. With CTRL_PERF_EN, CNT_W=4:
   - 17 retirements → retired=1 (wrap).
   - flushE on a valid E increments flushed; flushE on a bubble does not.
   - reset mid-run zeroes both counters.
